// File: rtl/eh2_dec_trigger_ctl.sv
// rtl/eh2_dec_trigger_ctl.sv - per-thread trigger config, round-robin CSR write arbiter and hit sequencer
// Holds tdata1/tdata2 for 4 triggers per thread and turns committed matches into hit bits and halt/exception pulses.
module eh2_dec_trigger_ctl #(
  parameter int NUM_THREADS = 2
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic [NUM_THREADS-1:0]        csr_wr_valid,
  output logic [NUM_THREADS-1:0]        csr_wr_ready,
  input  logic [NUM_THREADS*2-1:0]      csr_wr_trig,
  input  logic [NUM_THREADS-1:0]        csr_wr_sel,
  input  logic [NUM_THREADS*32-1:0]     csr_wr_data,
  input  logic [NUM_THREADS-1:0]        dbg_mode,
  input  logic                          commit_valid,
  input  logic                          commit_tid,
  input  logic [3:0]                    commit_match,
  output logic [NUM_THREADS*4*36-1:0]   trigger_pkt_any,
  output logic [NUM_THREADS*4-1:0]      trig_hit,
  output logic [NUM_THREADS-1:0]        trig_halt_req,
  output logic [NUM_THREADS-1:0]        trig_exc_req
);

  localparam int NT    = NUM_THREADS;
  localparam int PKT_W = 36;

  // Per-thread, per-trigger tdata1 fields; chain exists only for the low trigger of each pair.
  logic [NT-1:0][3:0]        dmode_q;
  logic [NT-1:0][3:0]        hit_q;
  logic [NT-1:0][3:0]        select_q;
  logic [NT-1:0][3:0]        action_q;
  logic [NT-1:0][3:0]        match_q;
  logic [NT-1:0][3:0]        m_q;
  logic [NT-1:0][3:0]        exe_q;
  logic [NT-1:0][1:0]        chain_q;
  logic [NT-1:0][3:0][31:0]  tdata2_q;
  logic [NT-1:0]             halt_q;
  logic [NT-1:0]             exc_q;

  logic [NT-1:0]             grant;

  generate
    if (NT == 1) begin : g_rr1
      assign grant = csr_wr_valid;
    end else begin : g_rr2
      logic rr_q;

      always_comb begin
        grant = '0;
        if (csr_wr_valid[rr_q]) begin
          grant[rr_q] = 1'b1;
        end else if (csr_wr_valid[~rr_q]) begin
          grant[~rr_q] = 1'b1;
        end
      end

      // Pointer moves past the thread just served.
      always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
          rr_q <= 1'b0;
        end else if (|grant) begin
          rr_q <= grant[0];
        end
      end
    end
  endgenerate

  assign csr_wr_ready = grant & {NT{rst_l}};

  logic [1:0]    wr_trig;
  logic          wr_sel;
  logic [31:0]   wr_data;
  logic          wr_dbg;
  logic [NT-1:0] wr_en;

  // A granted write to a dmode-locked trigger outside debug mode is acknowledged but dropped.
  always_comb begin
    wr_trig = '0;
    wr_sel  = 1'b0;
    wr_data = '0;
    wr_dbg  = 1'b0;
    wr_en   = '0;
    for (int t = 0; t < NT; t++) begin
      if (grant[t]) begin
        wr_trig  = csr_wr_trig[t*2 +: 2];
        wr_sel   = csr_wr_sel[t];
        wr_data  = csr_wr_data[t*32 +: 32];
        wr_dbg   = dbg_mode[t];
        wr_en[t] = ~(dmode_q[t][csr_wr_trig[t*2 +: 2]] & ~dbg_mode[t]);
      end
    end
  end

  logic [NT-1:0][3:0] fired;
  logic [3:0]         em;

  always_comb begin
    fired = '0;
    em    = '0;
    for (int t = 0; t < NT; t++) begin
      em = commit_match & exe_q[t] & m_q[t];
      if (commit_valid && (NT == 1 || commit_tid == 1'(t))) begin
        for (int p = 0; p < 2; p++) begin
          if (chain_q[t][p]) begin
            fired[t][2*p +: 2] = {2{em[2*p] & em[2*p+1]}};
          end else begin
            fired[t][2*p +: 2] = em[2*p +: 2];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      dmode_q  <= '0;
      hit_q    <= '0;
      select_q <= '0;
      action_q <= '0;
      match_q  <= '0;
      m_q      <= '0;
      exe_q    <= '0;
      chain_q  <= '0;
      tdata2_q <= '0;
      halt_q   <= '0;
      exc_q    <= '0;
    end else begin
      for (int t = 0; t < NT; t++) begin
        halt_q[t] <= |(fired[t] & action_q[t]);
        exc_q[t]  <= |(fired[t] & ~action_q[t]) & ~|(fired[t] & action_q[t]);
        for (int i = 0; i < 4; i++) begin
          hit_q[t][i] <= hit_q[t][i] | fired[t][i];
          if (wr_en[t] && wr_trig == 2'(i)) begin
            if (wr_sel) begin
              tdata2_q[t][i] <= wr_data;
            end else begin
              // Written hit value lands first, a same-cycle fire is OR-ed on top.
              dmode_q[t][i]  <= wr_data[27] & wr_dbg;
              hit_q[t][i]    <= wr_data[20] | fired[t][i];
              select_q[t][i] <= wr_data[19];
              action_q[t][i] <= wr_data[12];
              match_q[t][i]  <= wr_data[7];
              m_q[t][i]      <= wr_data[6];
              exe_q[t][i]    <= wr_data[2];
              if (i % 2 == 0) begin
                chain_q[t][i/2] <= wr_data[11];
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    trigger_pkt_any = '0;
    trig_hit        = '0;
    for (int t = 0; t < NT; t++) begin
      for (int i = 0; i < 4; i++) begin
        trigger_pkt_any[(t*4+i)*PKT_W +: PKT_W] =
          {select_q[t][i], match_q[t][i], exe_q[t][i], m_q[t][i], tdata2_q[t][i]};
        trig_hit[t*4+i] = hit_q[t][i];
      end
    end
  end

  assign trig_halt_req = halt_q;
  assign trig_exc_req  = exc_q;

endmodule

// File: doc/eh2_dec_trigger_ctl.md
Name: eh2_dec_trigger_ctl

Overview:
Per-thread trigger configuration and hit sequencer for the decode trigger compare logic. Holds tdata1/tdata2 state for 4 triggers per thread and drives the trigger packet array that the decode match logic consumes. Arbitrates CSR writes from all threads onto one shared write path using round-robin. Takes committed match vectors, applies chaining, records hit bits, and issues one-cycle debug-halt or breakpoint-exception requests.

Parameters:
NUM_THREADS, 2, number of hardware threads (1 or 2); NT below.

Ports:
clk  in  1  core clock
rst_l  in  1  asynchronous active-low reset
csr_wr_valid  in  NT  per-thread trigger CSR write request
csr_wr_ready  out  NT  write accepted this cycle (grant)
csr_wr_trig  in  NT*2  target trigger index
csr_wr_sel  in  NT  0 = tdata1, 1 = tdata2
csr_wr_data  in  NT*32  write data
dbg_mode  in  NT  thread is in debug mode
commit_valid  in  1  committed instruction carries match info
commit_tid  in  1  committing thread (ignored when NT=1)
commit_match  in  4  raw per-trigger match from decode compare
trigger_pkt_any  out  NT*4*pkt  select, match, execute, m, tdata2[31:0] per trigger
trig_hit  out  NT*4  sticky hit bits (tdata1.hit)
trig_halt_req  out  NT  1-cycle pulse: action=1 (enter debug)
trig_exc_req  out  NT  1-cycle pulse: action=0 (breakpoint)

Behaviour:
- Reset (async assert, sync release): all tdata1 fields and tdata2 = 0; trig_hit = 0; csr_wr_ready = 0; halt/exc = 0; round-robin pointer = thread 0.
- tdata1 layout: [27] dmode, [20] hit, [19] select, [12] action, [11] chain, [7] match, [6] m, [2] execute; all other bits read as 0 and are not stored.
- Arbitration: at most one write per cycle. Grant goes to the requester at or after the RR pointer. The pointer advances past the granted thread. csr_wr_ready is combinational from valid and pointer. The write lands on the next clk edge.
- Requester protocol: holds valid/trig/sel/data stable until ready. A valid with no grant gets ready=0 and no state change.
- dmode lock: if the target trigger has dmode=1 and dbg_mode[tid]=0, the write is granted (ready=1) but discarded. Writing dmode=1 while not in debug mode forces dmode to 0.
- Chain restriction: chain is writable only on triggers 0 and 2. Writes to bit 11 of triggers 1 and 3 are ignored.
- Effective match at commit: em[i] = commit_match[i] & execute[i] & m[i].
- Chain rule for pairs (0,1) and (2,3): if chain[lo]=1, both bits fire only when em[lo] & em[hi]; otherwise neither fires. If chain[lo]=0, each bit fires independently.
- Fired trigger: hit bit set on the next edge (sticky; cleared only by a tdata1 write with bit 20 = 0).
- Action pulses, one cycle after commit_valid, targeting commit_tid:
  - trig_halt_req when any fired trigger has action=1.
  - trig_exc_req when any fired trigger has action=0 and none has action=1. Halt takes priority.
- Same-cycle tdata1 write and hit set on the same trigger: the written value is stored, then the hit is OR-ed in, so hit = wr_data[20] | fired.
- Same-cycle write and commit on one trigger: the commit uses the pre-write config.
- trigger_pkt_any is registered state and reflects a write the cycle after the grant.
- NT=1: commit_tid and thread-1 ports are ignored. The RR pointer is constant.
- Reset asserted mid-write or mid-pulse: everything clears immediately. A pending write is lost and the requester must re-issue.
- Zero-latency path: none. Grant is combinational; all other outputs are registered.

Test Plan:
- Reset then idle: rst_l low at random phase -> all outputs 0, trigger_pkt_any all-zero, no pulses for 20 cycles.
- Both threads valid for 4 cycles (tdata2 writes to trigger 1, 0x1000 vs 0x2000) -> grants alternate T0,T1,T0,T1; final T0.tdata2 = 0x1000, T1.tdata2 = 0x2000, visible one cycle after each grant.
- T0 tdata1 trigger 0 = execute|m|action=1; commit_valid, tid=0, match=4'b0001 -> trig_hit[0] = 0001 next cycle, trig_halt_req[0] pulses exactly 1 cycle, exc stays 0.
- Chain: trigger 0 chain=1, triggers 0 and 1 execute|m|action=0; match=0001 -> no hit, no pulse; match=0011 -> hit=0011 and trig_exc_req for 1 cycle.
- dmode lock: write trigger 2 dmode=1 in debug mode, then a tdata2 write with dbg_mode=0 -> ready=1, tdata2 unchanged. Same write with dbg_mode=1 -> updated.
- Collision: tdata1 write hit=0 to trigger 3 in the same cycle as a fired commit on trigger 3 -> hit[3] = 1 after the edge, other written fields stored.
